// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mem_port_arbiter                                           |
// | Description : Shares one single-ported memory between instruction fetch  |
// |               and MEM-stage data access. Each access takes one IDLE      |
// |               arbitration cycle, WAIT_CYCLES+1 ACCESS cycles and one     |
// |               RESP cycle that pulses the owner's valid.                  |
// | Option      : define ARB_STARVE_GUARD_EN to force a fetch grant after    |
// |               STARVE_MAX back-to-back data grants with fetch pending.    |
// | Ports       : clk, rst (sync, active-high)                               |
// |               fetch : i_if_req/i_if_addr -> o_if_gnt/o_if_rdata/         |
// |                       o_if_valid/o_stall_if                              |
// |               data  : i_d_req/i_d_we/i_d_addr/i_d_wdata -> o_d_gnt/      |
// |                       o_d_rdata/o_d_valid/o_stall_d                      |
// |               memory: o_mem_en/o_mem_we/o_mem_addr/o_mem_wdata,          |
// |                       i_mem_rdata                                        |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module mem_port_arbiter #(
  parameter int AW          = 16,
  parameter int DW          = 16,
  parameter int WAIT_CYCLES = 1,
  parameter int STARVE_MAX  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_if_req,
  input  logic [AW-1:0] i_if_addr,
  output logic          o_if_gnt,
  output logic [DW-1:0] o_if_rdata,
  output logic          o_if_valid,
  output logic          o_stall_if,
  input  logic          i_d_req,
  input  logic          i_d_we,
  input  logic [AW-1:0] i_d_addr,
  input  logic [DW-1:0] i_d_wdata,
  output logic          o_d_gnt,
  output logic [DW-1:0] o_d_rdata,
  output logic          o_d_valid,
  output logic          o_stall_d,
  output logic          o_mem_en,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata
);

  // Wait-state counter is at least one bit wide even with zero wait states.
  localparam int            CW         = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] COUNT_LAST = CW'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic          owner_d;      // 1: data side owns the current access
  logic [CW-1:0] count;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          we_q;
  logic [DW-1:0] if_rdata_q;
  logic [DW-1:0] d_rdata_q;

  logic any_req;
  logic pick_d;
  logic force_fetch;
  logic count_done;
  logic in_access;

  assign any_req    = i_if_req | i_d_req;
  assign pick_d     = i_d_req & ~(i_if_req & force_fetch);
  assign count_done = (count == COUNT_LAST);
  assign in_access  = (state == ACCESS);

  // ------------------------------------------------------------------------
  // State register and next-state logic
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req)    state_next = ACCESS;
      ACCESS:  if (count_done) state_next = RESP;
      RESP:                    state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // ------------------------------------------------------------------------
  // Access datapath: owner/request latch, wait-state count, read capture
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_d    <= 1'b0;
      count      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          count <= '0;
          if (any_req) begin
            owner_d <= pick_d;
            addr_q  <= pick_d ? i_d_addr : i_if_addr;
            wdata_q <= pick_d ? i_d_wdata : '0;
            we_q    <= pick_d & i_d_we;
          end
        end
        ACCESS: begin
          if (count_done) begin
            count <= '0;
            // Stores leave the data read register untouched.
            if (!owner_d)   if_rdata_q <= i_mem_rdata;
            else if (!we_q) d_rdata_q  <= i_mem_rdata;
          end else begin
            count <= count + CW'(1);
          end
        end
        default: count <= '0;
      endcase
    end
  end

  // ------------------------------------------------------------------------
  // Fetch starvation guard
  // ------------------------------------------------------------------------
`ifdef ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_cnt;

  assign force_fetch = (starve_cnt >= SW'(STARVE_MAX));

  // Counts data grants made while fetch is waiting; a fetch grant or an
  // idle fetch side restarts the run.
  always_ff @(posedge clk) begin
    if (rst || !i_if_req) begin
      starve_cnt <= '0;
    end else if (state == IDLE && any_req) begin
      if (!pick_d)           starve_cnt <= '0;
      else if (!force_fetch) starve_cnt <= starve_cnt + SW'(1);
    end
  end
`else
  assign force_fetch = 1'b0;

  // Threshold has no effect with strict data priority.
  logic [31:0] unused_starve_max;
  assign unused_starve_max = STARVE_MAX;
`endif

  // ------------------------------------------------------------------------
  // Outputs: memory bus is driven only while in ACCESS, zero otherwise
  // ------------------------------------------------------------------------
  assign o_mem_en    = in_access;
  assign o_mem_we    = in_access & we_q & (count == '0);
  assign o_mem_addr  = in_access ? addr_q : '0;
  assign o_mem_wdata = in_access ? wdata_q : '0;

  assign o_if_gnt    = in_access & ~owner_d;
  assign o_d_gnt     = in_access &  owner_d;
  assign o_if_valid  = (state == RESP) & ~owner_d;
  assign o_d_valid   = (state == RESP) &  owner_d;
  assign o_if_rdata  = if_rdata_q;
  assign o_d_rdata   = d_rdata_q;

  assign o_stall_if  = i_if_req & ~o_if_valid;
  assign o_stall_d   = i_d_req  & ~o_d_valid;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_mem_port_arbiter                                        |
// | Description : Self-checking bench for mem_port_arbiter. A WAIT_CYCLES=1  |
// |               instance runs against a scoreboard of expected read data;  |
// |               a WAIT_CYCLES=3 instance covers reset during an access.    |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_mem_port_arbiter;

`ifdef ARB_STARVE_GUARD_EN
  localparam int EXP_FIRST_F    = 5;
  localparam int EXP_STARVE_LAT = 19;
`else
  localparam int EXP_FIRST_F    = 0;
  localparam int EXP_STARVE_LAT = 27;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Main instance (WAIT_CYCLES = 1)
  logic        rst, if_req, d_req, d_we;
  logic [15:0] if_addr, d_addr, d_wdata;
  logic        if_gnt, if_valid, stall_if, d_gnt, d_valid, stall_d, mem_en, mem_we;
  logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

  // Second instance (WAIT_CYCLES = 3), fetch side only
  logic        rst3, if_req3, d_req3, d_we3;
  logic [15:0] if_addr3, d_addr3, d_wdata3;
  logic        if_gnt3, if_valid3, stall_if3, d_gnt3, d_valid3, stall_d3, mem_en3, mem_we3;
  logic [15:0] if_rdata3, d_rdata3, mem_addr3, mem_wdata3, mem_rdata3;

  mem_port_arbiter #(.AW(16), .DW(16), .WAIT_CYCLES(1), .STARVE_MAX(4)) u_dut (
    .clk(clk), .rst(rst),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_gnt(if_gnt), .o_if_rdata(if_rdata),
    .o_if_valid(if_valid), .o_stall_if(stall_if),
    .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
    .o_d_gnt(d_gnt), .o_d_rdata(d_rdata), .o_d_valid(d_valid), .o_stall_d(stall_d),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.AW(16), .DW(16), .WAIT_CYCLES(3), .STARVE_MAX(4)) u_dut3 (
    .clk(clk), .rst(rst3),
    .i_if_req(if_req3), .i_if_addr(if_addr3), .o_if_gnt(if_gnt3), .o_if_rdata(if_rdata3),
    .o_if_valid(if_valid3), .o_stall_if(stall_if3),
    .i_d_req(d_req3), .i_d_we(d_we3), .i_d_addr(d_addr3), .i_d_wdata(d_wdata3),
    .o_d_gnt(d_gnt3), .o_d_rdata(d_rdata3), .o_d_valid(d_valid3), .o_stall_d(stall_d3),
    .o_mem_en(mem_en3), .o_mem_we(mem_we3), .o_mem_addr(mem_addr3), .o_mem_wdata(mem_wdata3),
    .i_mem_rdata(mem_rdata3)
  );

  // Memory contents: fixed pattern, 0x0010 holds 0xBEEF, plus the last store.
  function automatic logic [15:0] base_fn(input logic [15:0] a);
    return (a == 16'h0010) ? 16'hBEEF : (a ^ 16'hC3A5);
  endfunction

  logic        wr_valid = 1'b0;
  logic [15:0] wr_addr  = 16'h0;
  logic [15:0] wr_data  = 16'h0;
  always @(posedge clk) begin
    if (mem_we === 1'b1) begin
      wr_valid <= 1'b1;
      wr_addr  <= mem_addr;
      wr_data  <= mem_wdata;
    end
  end
  assign mem_rdata  = (wr_valid && wr_addr == mem_addr) ? wr_data : base_fn(mem_addr);
  assign mem_rdata3 = mem_addr3 ^ 16'h5A5A;

  // Scoreboard state
  logic [15:0] if_q[$];
  logic [15:0] d_q[$];
  logic        sb_st_valid   = 1'b0;
  logic [15:0] sb_st_addr    = 16'h0;
  logic [15:0] sb_st_data    = 16'h0;
  logic [15:0] last_load_exp = 16'h0;

  function automatic logic [15:0] exp_read(input logic [15:0] a);
    return (sb_st_valid && sb_st_addr == a) ? sb_st_data : base_fn(a);
  endfunction

  int n_vec = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor: bus ownership, pulse width and scoreboard pops
  logic prev_if_valid = 1'b0;
  logic prev_d_valid  = 1'b0;
  always @(negedge clk) begin
    logic [15:0] e;
    if (rst === 1'b0) begin
      if (if_gnt) begin
        check("if_no_we", 32'(mem_we), 32'(0));
        check("if_mem_addr", 32'(mem_addr), 32'(if_addr));
      end
      if (d_gnt) check("d_mem_addr", 32'(mem_addr), 32'(d_addr));
      if (if_valid) begin
        check("if_pulse", 32'(prev_if_valid), 32'(0));
        if (if_q.size() == 0) check("if_unexpected_valid", 32'(if_q.size()), 32'(1));
        else begin
          e = if_q.pop_front();
          check("if_rdata", 32'(if_rdata), 32'(e));
        end
      end
      if (d_valid) begin
        check("d_pulse", 32'(prev_d_valid), 32'(0));
        if (d_q.size() == 0) check("d_unexpected_valid", 32'(d_q.size()), 32'(1));
        else begin
          e = d_q.pop_front();
          check("d_rdata", 32'(d_rdata), 32'(e));
        end
      end
    end
    prev_if_valid = if_valid;
    prev_d_valid  = d_valid;
  end

  task automatic do_fetch(input logic [15:0] a, output int lat);
    int   start;
    logic done;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = a; start = cyc;
    if_q.push_back(exp_read(a));
    done = 1'b0; lat = 0;
    for (int n = 0; n < 60 && !done; n++) begin
      @(negedge clk);
      if (if_valid) begin
        done = 1'b1; lat = cyc - start;
        check("stall_if_at_valid", 32'(stall_if), 32'(0));
      end else begin
        check("stall_if_wait", 32'(stall_if), 32'(1));
      end
    end
    check("if_done", 32'(done), 32'(1));
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  task automatic do_data(input logic we, input logic [15:0] a, input logic [15:0] wd,
                         output int lat, output int we_cycles);
    int   start;
    logic done;
    @(posedge clk); #1;
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; start = cyc;
    if (we) begin
      d_q.push_back(last_load_exp);
      sb_st_valid = 1'b1; sb_st_addr = a; sb_st_data = wd;
    end else begin
      last_load_exp = exp_read(a);
      d_q.push_back(last_load_exp);
    end
    done = 1'b0; lat = 0; we_cycles = 0;
    for (int n = 0; n < 60 && !done; n++) begin
      @(negedge clk);
      if (mem_we) begin
        we_cycles++;
        check("st_addr", 32'(mem_addr), 32'(a));
        check("st_wdata", 32'(mem_wdata), 32'(wd));
      end
      if (d_valid) begin
        done = 1'b1; lat = cyc - start;
      end else begin
        check("stall_d_wait", 32'(stall_d), 32'(1));
      end
    end
    check("d_done", 32'(done), 32'(1));
    @(posedge clk); #1;
    d_req = 1'b0; d_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int lat_f, lat_d, wec, first_f, grants, start3, v3;
    logic prev_g, now_g, done3;

    rst = 1'b1; if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    if_addr = 16'h0; d_addr = 16'h0; d_wdata = 16'h0;
    rst3 = 1'b1; if_req3 = 1'b0; d_req3 = 1'b0; d_we3 = 1'b0;
    if_addr3 = 16'h0; d_addr3 = 16'h0; d_wdata3 = 16'h0;

    // Reset: outputs zero, stalls follow the requests
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", 32'({if_gnt, d_gnt, if_valid, d_valid, mem_en, mem_we}), 32'(0));
    check("rst_mem_bus", {mem_addr, mem_wdata}, 32'(0));
    check("rst_rdata", {if_rdata, d_rdata}, 32'(0));
    check("rst_stalls", 32'({stall_if, stall_d}), 32'(2'b11));
    @(posedge clk); #1;
    if_req = 1'b0; d_req = 1'b0; rst = 1'b0; rst3 = 1'b0;
    @(negedge clk);
    check("post_rst_stalls", 32'({stall_if, stall_d}), 32'(0));

    // Single fetch
    do_fetch(16'h0010, lat_f);
    check("fetch_latency", 32'(lat_f), 32'(3));

    // Simultaneous fetch and load: data first, fetch right after
    fork
      do_fetch(16'h0020, lat_f);
      do_data(1'b0, 16'h8004, 16'h0, lat_d, wec);
    join
    check("load_latency", 32'(lat_d), 32'(3));
    check("fetch_after_data_latency", 32'(lat_f), 32'(7));

    // Store, then read it back
    do_data(1'b1, 16'h8000, 16'h1234, lat_d, wec);
    check("store_latency", 32'(lat_d), 32'(3));
    check("store_we_cycles", 32'(wec), 32'(1));
    do_data(1'b0, 16'h8000, 16'h0, lat_d, wec);
    check("load_back_we_cycles", 32'(wec), 32'(0));

    // Data held high with fetch pending: which grant goes to fetch
    first_f = 0;
    fork
      do_fetch(16'h0040, lat_f);
      begin
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h8008;
        grants = 0; prev_g = 1'b0;
        for (int n = 0; n < 120 && grants < 6; n++) begin
          @(negedge clk);
          now_g = if_gnt | d_gnt;
          if (now_g && !prev_g) begin
            grants++;
            if (d_gnt) begin
              last_load_exp = exp_read(16'h8008);
              d_q.push_back(last_load_exp);
            end else if (first_f == 0) begin
              first_f = grants;
            end
          end
          prev_g = now_g;
        end
        check("starve_grant_count", 32'(grants), 32'(6));
        @(posedge clk); #1;
        d_req = 1'b0;
      end
    join
    check("starve_first_fetch_grant", 32'(first_f), 32'(EXP_FIRST_F));
    check("starve_fetch_latency", 32'(lat_f), 32'(EXP_STARVE_LAT));
    repeat (8) @(posedge clk);

    // WAIT_CYCLES=3: reset during the second ACCESS cycle aborts the access
    @(posedge clk); #1;
    if_req3 = 1'b1; if_addr3 = 16'h0100;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("w3_gnt_before_rst", 32'(if_gnt3), 32'(1));
    rst3 = 1'b1; if_req3 = 1'b0;
    @(posedge clk); #1;
    rst3 = 1'b0;
    @(negedge clk);
    check("w3_idle_after_rst", 32'({if_gnt3, if_valid3, mem_en3}), 32'(0));
    v3 = 0;
    repeat (8) begin
      @(negedge clk);
      if (if_valid3) v3++;
    end
    check("w3_no_valid_after_abort", 32'(v3), 32'(0));

    // Fresh request on the WAIT_CYCLES=3 instance completes normally
    @(posedge clk); #1;
    if_req3 = 1'b1; if_addr3 = 16'h0200; start3 = cyc;
    done3 = 1'b0;
    for (int n = 0; n < 30 && !done3; n++) begin
      @(negedge clk);
      if (if_valid3) begin
        done3 = 1'b1;
        check("w3_latency", 32'(cyc - start3), 32'(5));
        check("w3_rdata", 32'(if_rdata3), 32'(16'h0200 ^ 16'h5A5A));
      end
    end
    check("w3_done", 32'(done3), 32'(1));
    @(posedge clk); #1;
    if_req3 = 1'b0;

    repeat (4) @(posedge clk);
    check("if_queue_drained", 32'(if_q.size()), 32'(0));
    check("d_queue_drained", 32'(d_q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
